instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Upstream stage of the 32-bit processor. Fetches instruction words from instruction memory over a req/ack bus, buffers them in a small prefetch FIFO and presents the head word on `instruction`. The head word is retired when the processor pulses `sys_dne`. Branch redirects flush the buffer and restart fetch at a new address.

Parameters:
- DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  one clock; reset is synchronous and active-low.
- mem_req  out  1  fetch request; held until mem_ack.
- mem_addr  out  32  word address of the current request.
- mem_ack  in  1  request accepted; mem_rdata valid in the same cycle.
- mem_rdata  in  32  fetched instruction word.
- instruction  out  32  FIFO head word to the processor; 0 when empty.
- instr_pc  out  32  address of the head word; 0 when empty.
- instr_valid  out  1  FIFO non-empty.
- sys_dne  in  1  processor finished the current instruction; pops the head.
- redirect  in  1  branch/jump taken.
- redirect_pc  in  32  new fetch address, sampled when redirect=1.

Behaviour:
- Reset (reset=0 at a clock edge):
  - mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC.
  - FIFO empty, so instr_valid=0, instruction=0, instr_pc=0.
  - state=IDLE.
  - Reset wins over every other input and aborts an in-flight request with no drain.
- Addressing: word addressed. fetch_pc increments by 1 on each accepted fetch; 32'hFFFF_FFFF wraps to 0.
- Outstanding requests: at most one. A new request is issued only when count+1 <= DEPTH, with the in-flight request counted.
- FSM states: IDLE, REQ, DISCARD.
  - IDLE -> REQ when there is space and no redirect. The request drives mem_req=1 and mem_addr=fetch_pc.
  - REQ: mem_req and mem_addr stay stable until mem_ack.
    - On mem_ack: push mem_rdata with its address, fetch_pc+=1.
    - Then go to REQ if space remains, otherwise IDLE.
    - Back-to-back requests are allowed, giving 1 word/cycle with a zero-wait memory.
  - DISCARD: entered on redirect while in REQ without mem_ack in that cycle.
    - mem_req stays high with the old address; a request is never withdrawn.
    - On mem_ack the data is dropped and the state goes to REQ at the redirected fetch_pc.
- Pop: sys_dne && instr_valid removes the head. sys_dne while empty is ignored.
- Simultaneous push and pop: count unchanged. Pop with a full FIFO frees space for a request in the next cycle.
- Redirect, at the edge:
  - FIFO is cleared and fetch_pc <= redirect_pc.
  - A concurrent pop or push is ignored.
  - If mem_ack arrives in the same cycle, that data is dropped and the state goes to REQ (or IDLE).
  - instr_valid is 0 in the cycle after a redirect.
- Latency: with mem_ack in the same cycle as mem_req, the first instruction_valid appears 2 cycles after reset release or redirect: request cycle, then push.
- Outputs are registered or taken from the FIFO head. No combinational path from mem_ack or mem_rdata to instruction.

Optional Feature:
- IFU_PERF_CNT_EN defined: adds 32-bit outputs fetch_count and flush_count.
  - fetch_count increments on every accepted mem_ack, discarded data included.
  - flush_count increments on every redirect.
  - Both reset to 0 and wrap at 2^32.
- Undefined: these ports and the counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IFU_IDLE, IFU_REQ, IFU_DISCARD);
  - the word width of 32;
  - the NOP/empty value 32'h0.
- Sub-module ifu_fifo: synchronous FIFO of {addr, data} with push, pop, clear, count, full and empty, sharing the same clk/reset.

Test Plan:
1. Reset, zero-wait memory returning data = addr ^ 32'h2AF6_0000, no sys_dne.
   - Expect mem_addr 0,1,2,3; then mem_req=0.
   - FIFO full; instruction=32'h2AF6_0000, instr_pc=0.
2. Then pulse sys_dne once.
   - Expect instruction=32'h2AF6_0001, instr_pc=1, then exactly one new request at addr 4.
3. mem_ack delayed 3 cycles.
   - Expect mem_req and mem_addr stable across the wait; exactly one push per ack.
4. Redirect to 32'h0000_0100 while a request to 5 is pending with no ack.
   - Expect state DISCARD, addr 5 held, its data dropped.
   - Next request at addr 0x100; first valid instr_pc=0x100.
5. Redirect, mem_ack and sys_dne in the same cycle.
   - Expect FIFO empty next cycle and the acked data absent.
   - fetch_pc=redirect_pc; with IFU_PERF_CNT_EN, flush_count+1 and fetch_count+1.
6. reset=0 asserted mid-REQ.
   - Expect all outputs at reset values next edge.
   - First post-reset request at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: fetch FSM state encoding and shared word constants.
package instr_fetch_unit_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_WORD = '0;
  typedef enum logic [1:0] {IFU_IDLE, IFU_REQ, IFU_DISCARD} ifu_state_t;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: prefetch FIFO of {addr, data} pairs with a synchronous clear.
module ifu_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [WORD_W-1:0]     in_addr,
  input  logic [WORD_W-1:0]     in_data,
  output logic [WORD_W-1:0]     head_addr,
  output logic [WORD_W-1:0]     head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [2*WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign {head_addr, head_data} = mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= {in_addr, in_data};
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      wr <= do_push ? wr + 1'b1 : wr;
      rd <= do_pop ? rd + 1'b1 : rd;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: req/ack instruction fetcher feeding a prefetch FIFO.
// Define IFU_PERF_CNT_EN to add fetch_count/flush_count performance counters.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] instruction,
  output logic [WORD_W-1:0] instr_pc,
  output logic              instr_valid,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]       fetch_count,
  output logic [31:0]       flush_count,
`endif
  input  logic              sys_dne,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  ifu_state_t state, state_n;
  logic [WORD_W-1:0] fetch_pc, fetch_pc_n, mem_addr_n, head_addr, head_data;
  logic [CW-1:0] count, count_n;
  logic full, empty, push, pop, space;
  assign mem_req = state != IFU_IDLE;
  assign push = mem_ack && state == IFU_REQ && !redirect && !full;
  assign pop = sys_dne && !empty && !redirect;
  assign count_n = count + CW'(push) - CW'(pop);
  assign space = count_n < CW'(DEPTH);
  assign instr_valid = !empty;
  assign instruction = empty ? NOP_WORD : head_data;
  assign instr_pc = empty ? NOP_WORD : head_addr;
  ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .clear(redirect),
    .in_addr(mem_addr), .in_data(mem_rdata), .head_addr(head_addr),
    .head_data(head_data), .count(count), .full(full), .empty(empty)
  );
  always_comb begin
    state_n = state;
    case (state)
      IFU_IDLE: state_n = (!redirect && space) ? IFU_REQ : IFU_IDLE;
      IFU_REQ: state_n = mem_ack ? ((redirect || space) ? IFU_REQ : IFU_IDLE)
                                 : (redirect ? IFU_DISCARD : IFU_REQ);
      IFU_DISCARD: state_n = mem_ack ? IFU_REQ : IFU_DISCARD;
      default: state_n = IFU_IDLE;
    endcase
    fetch_pc_n = redirect ? redirect_pc : push ? fetch_pc + 1'b1 : fetch_pc;
    // a discarded request keeps its old address on the bus until acked
    mem_addr_n = state_n == IFU_REQ ? fetch_pc_n : mem_addr;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IFU_IDLE;
      fetch_pc <= RESET_PC;
      mem_addr <= RESET_PC;
    end else begin
      state <= state_n;
      fetch_pc <= fetch_pc_n;
      mem_addr <= mem_addr_n;
    end
  end
`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      fetch_count <= fetch_count + 32'(mem_ack && mem_req);
      flush_count <= flush_count + 32'(redirect);
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table vectors plus hand sequences, checked against a queue scoreboard.
module tb_instr_fetch_unit;
  localparam logic [31:0] K = 32'h2AF6_0000;
  logic clk = 0, reset = 0, mem_ack = 0, sys_dne = 0, redirect = 0;
  logic mem_req, instr_valid;
  logic [31:0] mem_rdata = 0, redirect_pc = 0, mem_addr, instruction, instr_pc;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count, flush_count;
`endif
  always #5 clk = ~clk;
  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instruction(instruction),
    .instr_pc(instr_pc), .instr_valid(instr_valid),
`ifdef IFU_PERF_CNT_EN
    .fetch_count(fetch_count), .flush_count(flush_count),
`endif
    .sys_dne(sys_dne), .redirect(redirect), .redirect_pc(redirect_pc)
  );
  int total = 0, bad = 0;
  typedef struct packed {logic [31:0] pc; logic [31:0] data;} ent_t;
  ent_t q[$];
  logic [31:0] exp_pc = 0, held = 0, m_fetch = 0, m_flush = 0;
  logic discard = 0;
  typedef struct {
    logic dne, ack, req, valid;
    logic [31:0] addr, instr, pc;
  } vec_t;
  vec_t tbl[9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic dne, input logic redir, input logic [31:0] rpc, input logic ack_en);
    logic ack_now;
    @(negedge clk);
    ack_now = ack_en && mem_req;
    sys_dne = dne;
    redirect = redir;
    redirect_pc = rpc;
    mem_ack = ack_now;
    mem_rdata = mem_addr ^ K;
    if (mem_req && reset) chk("sb_mem_addr", mem_addr, discard ? held : exp_pc);
    if (!reset) begin
      q.delete();
      exp_pc = 0;
      discard = 0;
      m_fetch = 0;
      m_flush = 0;
    end else if (redir) begin
      q.delete();
      discard = mem_req && !ack_now;
      held = mem_addr;
      exp_pc = rpc;
      m_flush++;
      if (ack_now) m_fetch++;
    end else begin
      if (dne && q.size() > 0) void'(q.pop_front());
      if (ack_now) begin
        m_fetch++;
        if (discard) discard = 0;
        else begin
          q.push_back({mem_addr, mem_rdata});
          exp_pc = mem_addr + 1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("sb_valid", {31'b0, instr_valid}, {31'b0, q.size() != 0});
    chk("sb_instruction", instruction, q.size() != 0 ? q[0].data : 32'h0);
    chk("sb_instr_pc", instr_pc, q.size() != 0 ? q[0].pc : 32'h0);
`ifdef IFU_PERF_CNT_EN
    chk("fetch_count", fetch_count, m_fetch);
    chk("flush_count", flush_count, m_flush);
`endif
  endtask
  task automatic check_out(input logic req, input logic [31:0] addr, input logic valid,
                           input logic [31:0] instr, input logic [31:0] pc);
    chk("mem_req", {31'b0, mem_req}, {31'b0, req});
    chk("mem_addr", mem_addr, addr);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, valid});
    chk("instruction", instruction, instr);
    chk("instr_pc", instr_pc, pc);
  endtask
  initial begin
    tbl[0] = '{dne: 0, ack: 0, req: 1, addr: 0, valid: 0, instr: 0,     pc: 0};
    tbl[1] = '{dne: 0, ack: 1, req: 1, addr: 1, valid: 1, instr: K,     pc: 0};
    tbl[2] = '{dne: 0, ack: 1, req: 1, addr: 2, valid: 1, instr: K,     pc: 0};
    tbl[3] = '{dne: 0, ack: 1, req: 1, addr: 3, valid: 1, instr: K,     pc: 0};
    tbl[4] = '{dne: 0, ack: 1, req: 0, addr: 3, valid: 1, instr: K,     pc: 0};
    tbl[5] = '{dne: 0, ack: 1, req: 0, addr: 3, valid: 1, instr: K,     pc: 0};
    tbl[6] = '{dne: 1, ack: 0, req: 1, addr: 4, valid: 1, instr: K ^ 1, pc: 1};
    tbl[7] = '{dne: 0, ack: 1, req: 0, addr: 4, valid: 1, instr: K ^ 1, pc: 1};
    tbl[8] = '{dne: 0, ack: 1, req: 0, addr: 4, valid: 1, instr: K ^ 1, pc: 1};
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_out(0, 0, 0, 0, 0);
    reset = 1;
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].dne, 0, 0, tbl[i].ack);
      check_out(tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].instr, tbl[i].pc);
    end
    step(1, 0, 0, 0);
    check_out(1, 5, 1, K ^ 2, 2);
    step(0, 1, 32'h100, 0);
    check_out(1, 5, 0, 0, 0);
    step(1, 0, 0, 0);
    check_out(1, 5, 0, 0, 0);
    step(0, 0, 0, 1);
    check_out(1, 32'h100, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      check_out(1, 32'h100, 0, 0, 0);
    end
    step(0, 0, 0, 1);
    check_out(1, 32'h101, 1, 32'h100 ^ K, 32'h100);
    step(0, 0, 0, 1);
    check_out(1, 32'h102, 1, 32'h100 ^ K, 32'h100);
    step(1, 1, 32'h200, 1);
    check_out(1, 32'h200, 0, 0, 0);
    step(0, 0, 0, 1);
    check_out(1, 32'h201, 1, 32'h200 ^ K, 32'h200);
    step(1, 0, 0, 1);
    check_out(1, 32'h202, 1, 32'h201 ^ K, 32'h201);
    reset = 0;
    step(0, 0, 0, 0);
    check_out(0, 0, 0, 0, 0);
    reset = 1;
    step(0, 0, 0, 0);
    check_out(1, 0, 0, 0, 0);
    step(0, 0, 0, 1);
    check_out(1, 1, 1, K, 0);
    step(0, 1, 32'hFFFF_FFFF, 1);
    check_out(1, 32'hFFFF_FFFF, 0, 0, 0);
    step(0, 0, 0, 1);
    check_out(1, 0, 1, 32'hFFFF_FFFF ^ K, 32'hFFFF_FFFF);
    step(0, 0, 0, 1);
    check_out(1, 1, 1, 32'hFFFF_FFFF ^ K, 32'hFFFF_FFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
